bayer_window_5x5: RTL and testbench

Streaming 5x5 neighbourhood generator for the demosaic datapath. Accepts a raster-order Bayer pixel stream, one 10-bit pixel per valid beat, buffers four previous lines, and presents a registered 5x5 window as D11..D55. The window is consumed directly by the per-site interpolation filters (G at R/B, R/B at G, R/B at B/R). Also emits the Bayer phase of the window centre, so the downstream selector can pick the correct filter output.

---
 rtl/demosaic_pkg.sv | 27 ++
 rtl/bayer_line_buffer.sv | 36 +++
 rtl/bayer_window_5x5.sv | 196 +++++++++++++++++++
 tb/tb_bayer_window_5x5.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demosaic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demosaic_pkg
// Description : Shared widths and Bayer phase encodings for the demosaic
//               datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package demosaic_pkg;

    localparam int DATA_W    = 10;
    localparam int MAX_WIDTH = 2048;
    localparam int XW        = 11;

    // RGGB phase of a site, encoded as {y[0], x[0]}
    typedef enum logic [1:0] {
        PH_R  = 2'b00,
        PH_GR = 2'b01,
        PH_GB = 2'b10,
        PH_B  = 2'b11
    } bayer_phase_t;

    function automatic bayer_phase_t bayer_phase(input logic y_lsb, input logic x_lsb);
        return bayer_phase_t'({y_lsb, x_lsb});
    endfunction

endpackage
`default_nettype wire

// File: rtl/bayer_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : bayer_line_buffer
// Description : One line of pixel storage, read-before-write. The read port
//               is asynchronous so the old pixel at a column is available in
//               the same cycle the new pixel is written there.
// Revision    : 1.0 - initial release
// ============================================================================
module bayer_line_buffer
    import demosaic_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = MAX_WIDTH,
    parameter int AW    = XW
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store the incoming pixel; contents are never reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_data;
        end
    end

    // Old content at the current column, seen before this cycle's write lands
    assign o_data = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/bayer_window_5x5.sv
`default_nettype none
// ============================================================================
// Module      : bayer_window_5x5
// Description : Streaming 5x5 neighbourhood generator over a raster Bayer
//               stream. Four chained line buffers feed a 5x5 column shift
//               register; interior windows are registered to D11..D55 with
//               centre coordinates and Bayer phase.
// Revision    : 1.0 - initial release
// ============================================================================
module bayer_window_5x5
    import demosaic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [XW-1:0]     cfg_width,
    input  logic [XW-1:0]     cfg_height,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] D11, D12, D13, D14, D15,
    output logic [DATA_W-1:0] D21, D22, D23, D24, D25,
    output logic [DATA_W-1:0] D31, D32, D33, D34, D35,
    output logic [DATA_W-1:0] D41, D42, D43, D44, D45,
    output logic [DATA_W-1:0] D51, D52, D53, D54, D55,
    output logic              out_valid,
    output logic [1:0]        out_phase,
    output logic [XW-1:0]     out_x,
    output logic [XW-1:0]     out_y,
    output logic              out_eof
);

    localparam int c_N     = 5;
    localparam int c_LINES = 4;

    // Frame tracking: r_x/r_y hold the position the next accepted pixel takes
    logic              r_active;
    logic [XW-1:0]     r_x;
    logic [XW-1:0]     r_y;
    logic [XW-1:0]     r_width;
    logic [XW-1:0]     r_height;

    logic              w_accept;
    logic [XW-1:0]     w_px;
    logic [XW-1:0]     w_py;
    logic [XW-1:0]     w_wlast;
    logic [XW-1:0]     w_hlast;
    logic              w_row_end;
    logic              w_frame_end;
    logic              w_interior;

    // w_tap[0] is the incoming pixel, w_tap[k] is the output of line k
    logic [c_LINES:0][DATA_W-1:0]       w_tap;

    logic [c_N-1:0][c_N-1:0][DATA_W-1:0] r_win;
    logic [c_N-1:0][c_N-1:0][DATA_W-1:0] w_win_next;
    logic [c_N-1:0][c_N-1:0][DATA_W-1:0] r_d;

    logic              r_valid;
    logic              r_eof;
    logic [XW-1:0]     r_ox;
    logic [XW-1:0]     r_oy;

    // A start-of-frame beat is always taken; other beats only inside a frame
    assign w_accept = in_valid & (in_sof | r_active);
    assign w_px     = in_sof ? '0 : r_x;
    assign w_py     = in_sof ? '0 : r_y;

    // Last column/row in XW-bit arithmetic; a width of 0 wraps at MAX_WIDTH-1,
    // which is how a full MAX_WIDTH line is expressed on an XW-bit port
    assign w_wlast     = (in_sof ? cfg_width  : r_width)  - XW'(1);
    assign w_hlast     = (in_sof ? cfg_height : r_height) - XW'(1);
    assign w_row_end   = (w_px == w_wlast);
    assign w_frame_end = w_row_end & (w_py == w_hlast);
    assign w_interior  = (w_px >= XW'(4)) & (w_py >= XW'(4));

    // Position counters, frame-active flag and latched geometry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_width  <= '0;
            r_height <= '0;
        end else if (w_accept) begin
            if (in_sof) begin
                r_width  <= cfg_width;
                r_height <= cfg_height;
            end
            if (w_frame_end) begin
                r_active <= 1'b0;
                r_x      <= '0;
                r_y      <= '0;
            end else begin
                r_active <= 1'b1;
                if (w_row_end) begin
                    r_x <= '0;
                    r_y <= w_py + XW'(1);
                end else begin
                    r_x <= w_px + XW'(1);
                    r_y <= w_py;
                end
            end
        end
    end

    assign w_tap[0] = in_data;

    for (genvar k = 0; k < c_LINES; k++) begin : g_line
        bayer_line_buffer #(
            .WIDTH (DATA_W),
            .DEPTH (MAX_WIDTH),
            .AW    (XW)
        ) u_line (
            .clk     (clk),
            .i_wr_en (w_accept),
            .i_addr  (w_px),
            .i_data  (w_tap[k]),
            .o_data  (w_tap[k+1])
        );
    end

    // Shift columns left; row 0 (oldest line) takes line 4, row 4 the new pixel
    always_comb begin
        w_win_next = r_win;
        for (int r = 0; r < c_N; r++) begin
            for (int c = 0; c < c_N - 1; c++) begin
                w_win_next[r][c] = r_win[r][c+1];
            end
            w_win_next[r][c_N-1] = w_tap[c_LINES-r];
        end
    end

    // Column shift register advances on every accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
        end else if (w_accept) begin
            r_win <= w_win_next;
        end
    end

    // Output window and its tags, captured only for interior centres
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d     <= '0;
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
            r_ox    <= '0;
            r_oy    <= '0;
        end else begin
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
            if (w_accept && w_interior) begin
                r_d     <= w_win_next;
                r_valid <= 1'b1;
                r_eof   <= w_frame_end;
                r_ox    <= w_px - XW'(2);
                r_oy    <= w_py - XW'(2);
            end
        end
    end

    assign out_valid = r_valid;
    assign out_eof   = r_eof;
    assign out_x     = r_ox;
    assign out_y     = r_oy;
    assign out_phase = bayer_phase(r_oy[0], r_ox[0]);

    assign D11 = r_d[0][0];
    assign D12 = r_d[0][1];
    assign D13 = r_d[0][2];
    assign D14 = r_d[0][3];
    assign D15 = r_d[0][4];
    assign D21 = r_d[1][0];
    assign D22 = r_d[1][1];
    assign D23 = r_d[1][2];
    assign D24 = r_d[1][3];
    assign D25 = r_d[1][4];
    assign D31 = r_d[2][0];
    assign D32 = r_d[2][1];
    assign D33 = r_d[2][2];
    assign D34 = r_d[2][3];
    assign D35 = r_d[2][4];
    assign D41 = r_d[3][0];
    assign D42 = r_d[3][1];
    assign D43 = r_d[3][2];
    assign D44 = r_d[3][3];
    assign D45 = r_d[3][4];
    assign D51 = r_d[4][0];
    assign D52 = r_d[4][1];
    assign D53 = r_d[4][2];
    assign D54 = r_d[4][3];
    assign D55 = r_d[4][4];

endmodule
`default_nettype wire

// File: tb/tb_bayer_window_5x5.sv
`default_nettype none
// ============================================================================
// Module      : tb_bayer_window_5x5
// Description : Scoreboard bench for bayer_window_5x5 with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bayer_window_5x5;
    import demosaic_pkg::*;

    typedef struct {
        logic [24:0][DATA_W-1:0] win;
        int                      x;
        int                      y;
        logic [1:0]              ph;
        bit                      eof;
        int                      cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [XW-1:0]     cfg_width;
    logic [XW-1:0]     cfg_height;
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] D11, D12, D13, D14, D15;
    logic [DATA_W-1:0] D21, D22, D23, D24, D25;
    logic [DATA_W-1:0] D31, D32, D33, D34, D35;
    logic [DATA_W-1:0] D41, D42, D43, D44, D45;
    logic [DATA_W-1:0] D51, D52, D53, D54, D55;
    logic              out_valid;
    logic [1:0]        out_phase;
    logic [XW-1:0]     out_x;
    logic [XW-1:0]     out_y;
    logic              out_eof;

    logic [24:0][DATA_W-1:0] dw;
    assign dw = {D55, D54, D53, D52, D51, D45, D44, D43, D42, D41,
                 D35, D34, D33, D32, D31, D25, D24, D23, D22, D21,
                 D15, D14, D13, D12, D11};

    bayer_window_5x5 dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .D11(D11), .D12(D12), .D13(D13), .D14(D14), .D15(D15),
        .D21(D21), .D22(D22), .D23(D23), .D24(D24), .D25(D25),
        .D31(D31), .D32(D32), .D33(D33), .D34(D34), .D35(D35),
        .D41(D41), .D42(D42), .D43(D43), .D44(D44), .D45(D45),
        .D51(D51), .D52(D52), .D53(D53), .D54(D54), .D55(D55),
        .out_valid  (out_valid),
        .out_phase  (out_phase),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_eof    (out_eof)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    int   tests_run = 0;
    int   fails     = 0;
    int   win_cnt   = 0;
    int   eof_cnt   = 0;
    logic [24:0][DATA_W-1:0] first_win, last_win;
    int   first_x, first_y, last_x, last_y;
    logic [1:0] first_ph;
    bit   last_eof;

    function automatic logic [DATA_W-1:0] pix(input int base, input int mul, input int x, input int y);
        int v;
        v = base + mul * y + x;
        return v[DATA_W-1:0];
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        tests_run++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Monitor: pop one expectation per presented window and compare
    always @(negedge clk) begin
        exp_t e;
        int   bad;
        if (!rst && out_valid) begin
            tests_run++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL window_unexpected: got window x=%0d y=%0d, required none", out_x, out_y);
            end else begin
                e   = sb.pop_front();
                bad = -1;
                for (int i = 24; i >= 0; i--) if (dw[i] !== e.win[i]) bad = i;
                if (bad >= 0 || out_x !== XW'(e.x) || out_y !== XW'(e.y) ||
                    out_phase !== e.ph || out_eof !== e.eof || cyc != e.cyc) begin
                    fails++;
                    if (bad < 0) bad = 0;
                    $display("FAIL window: got x=%0d y=%0d ph=%0d eof=%0d cyc=%0d D[%0d]=%0d, required x=%0d y=%0d ph=%0d eof=%0d cyc=%0d D[%0d]=%0d",
                             out_x, out_y, out_phase, out_eof, cyc, bad, dw[bad],
                             e.x, e.y, e.ph, e.eof, e.cyc, bad, e.win[bad]);
                end
            end
            if (win_cnt == 0) begin
                first_win = dw;
                first_x   = int'(out_x);
                first_y   = int'(out_y);
                first_ph  = out_phase;
            end
            last_win = dw;
            last_x   = int'(out_x);
            last_y   = int'(out_y);
            last_eof = out_eof;
            if (out_eof) eof_cnt++;
            win_cnt++;
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Beats without in_sof that the DUT must ignore
    task automatic drop_beats(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sof   = 1'b0;
            in_data  = DATA_W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Send the first nbeats pixels of a w x h frame, pushing expected windows
    task automatic send_frame(input int w, input int h, input int base, input int mul,
                              input int gap, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int   x;
            int   y;
            int   g;
            exp_t e;
            x = i % w;
            y = i / w;
            if (gap > 0) begin
                g = $urandom_range(gap, 0);
                idle(g);
            end
            in_valid = 1'b1;
            in_sof   = (i == 0);
            in_data  = pix(base, mul, x, y);
            if (i == 0) begin
                cfg_width  = XW'(w);
                cfg_height = XW'(h);
            end else begin
                cfg_width  = XW'($urandom);
                cfg_height = XW'($urandom);
            end
            if (x >= 4 && y >= 4) begin
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        e.win[r*5+c] = pix(base, mul, x - 4 + c, y - 4 + r);
                e.x     = x - 2;
                e.y     = y - 2;
                e.ph[1] = ((y - 2) % 2) != 0;
                e.ph[0] = ((x - 2) % 2) != 0;
                e.eof   = (x == w - 1) && (y == h - 1);
                e.cyc   = cyc + 1;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < 25; i++) if (dw[i] != '0) nz++;
        check({tag, "_D_nonzero"}, nz, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_x"}, out_x, 0);
        check({tag, "_y"}, out_y, 0);
        check({tag, "_phase"}, out_phase, 0);
        check({tag, "_eof"}, out_eof, 0);
    endtask

    initial begin
        cfg_width  = 8;
        cfg_height = 6;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        in_data    = '0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Beats before any in_sof are dropped
        win_cnt = 0;
        drop_beats(40);
        idle(3);
        check("drop_presof_windows", win_cnt, 0);

        // Ramp 8x6, continuous, then beats after frame end
        win_cnt = 0;
        eof_cnt = 0;
        send_frame(8, 6, 0, 16, 0, 48);
        idle(3);
        drop_beats(20);
        idle(3);
        check("ramp_count", win_cnt, 8);
        check("ramp_first_D11", first_win[0], 0);
        check("ramp_first_D33", first_win[12], 34);
        check("ramp_first_D55", first_win[24], 68);
        check("ramp_first_x", first_x, 2);
        check("ramp_first_y", first_y, 2);
        check("ramp_first_phase", first_ph, 0);
        check("ramp_last_D55", last_win[24], 'h57);
        check("ramp_last_eof", last_eof, 1);
        check("ramp_eof_count", eof_cnt, 1);

        // Same frame with idle gaps between beats
        win_cnt = 0;
        send_frame(8, 6, 0, 16, 5, 48);
        idle(8);
        check("gap_count", win_cnt, 8);
        check("gap_first_D33", first_win[12], 34);
        check("gap_last_D55", last_win[24], 'h57);

        // Reset mid-frame at pixel (3,4) of a 16x8 frame
        win_cnt = 0;
        send_frame(16, 8, 200, 16, 0, 67);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drop_beats(30);
        idle(3);
        check("midrst_no_windows", win_cnt, 0);
        win_cnt = 0;
        send_frame(16, 8, 700, 16, 0, 128);
        idle(3);
        check("midrst_next_count", win_cnt, 48);

        // Restart at (5,3) of a 16x8 frame into a 16x12 frame
        win_cnt = 0;
        eof_cnt = 0;
        send_frame(16, 8, 100, 16, 0, 53);
        send_frame(16, 12, 500, 16, 0, 192);
        idle(3);
        check("restart_count", win_cnt, 96);
        check("restart_first_D33", first_win[12], 534);
        check("restart_eof_count", eof_cnt, 1);

        // in_sof arriving in place of the final beat of a frame
        win_cnt = 0;
        eof_cnt = 0;
        send_frame(8, 6, 40, 16, 0, 47);
        send_frame(8, 6, 60, 16, 0, 48);
        idle(3);
        check("sof_final_count", win_cnt, 15);
        check("sof_final_eof_count", eof_cnt, 1);

        // Widest line, minimum height
        win_cnt = 0;
        send_frame(MAX_WIDTH, 5, 3, 37, 0, MAX_WIDTH * 5);
        idle(3);
        check("limit_count", win_cnt, 2044);
        check("limit_first_x", first_x, 2);
        check("limit_last_x", last_x, 2045);
        check("limit_last_y", last_y, 2);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required completion before time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
